// File: rtl/lfsr_checker.sv
// Receive-side checker for the 8-bit game LFSR.
// It locks onto the word stream, flywheels its prediction and counts mismatches while locked.
module lfsr_checker #(
  parameter int unsigned SYNC_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      word_count
);

  localparam int unsigned RunW  = $clog2(SYNC_COUNT + 1);
  localparam int unsigned MissW = $clog2(LOSS_COUNT + 1);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e             state_q, state_d;
  logic [7:0]         pred_q, pred_d;
  logic [RunW-1:0]    run_q, run_d;
  logic [MissW-1:0]   miss_q, miss_d;
  logic               err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic [15:0]        word_count_q, word_count_d;

  // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0
  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StHunt;
      pred_q       <= '0;
      run_q        <= '0;
      miss_q       <= '0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      pred_q       <= pred_d;
      run_q        <= run_d;
      miss_q       <= miss_d;
      err_pulse_q  <= err_pulse_d;
      err_count_q  <= err_count_d;
      word_count_q <= word_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pred_d       = pred_q;
    run_d        = run_q;
    miss_d       = miss_q;
    err_pulse_d  = 1'b0;
    err_count_d  = err_count_q;
    word_count_d = word_count_q;

    if (clear) begin
      state_d      = StHunt;
      pred_d       = '0;
      run_d        = '0;
      miss_d       = '0;
      err_count_d  = '0;
      word_count_d = '0;
    end else if (data_valid) begin
      unique case (state_q)
        StHunt: begin
          if (data_in == 8'h00) begin
            // Lockup value: never a seed, and it breaks any run in progress.
            run_d = '0;
          end else if (data_in == pred_q) begin
            pred_d = lfsr_next(data_in);
            if (run_q == RunW'(SYNC_COUNT - 1)) begin
              state_d = StLocked;
              run_d   = '0;
              miss_d  = '0;
            end else begin
              run_d = run_q + RunW'(1);
            end
          end else begin
            pred_d = lfsr_next(data_in);
            run_d  = '0;
          end
        end
        StLocked: begin
          word_count_d = word_count_q + 16'd1;
          // Flywheel: the prediction never follows the data once locked.
          pred_d = lfsr_next(pred_q);
          if (data_in != pred_q) begin
            err_pulse_d = 1'b1;
            if (err_count_q != {ERR_W{1'b1}}) begin
              err_count_d = err_count_q + ERR_W'(1);
            end
            if (miss_q == MissW'(LOSS_COUNT - 1)) begin
              state_d = StHunt;
              run_d   = '0;
              pred_d  = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + MissW'(1);
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_comb begin
    locked     = (state_q == StLocked);
    err_pulse  = err_pulse_q;
    err_count  = err_count_q;
    word_count = word_count_q;
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, clean stream, corruption, loss, clear, reset, saturation.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        clear;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [15:0] word_count;

  logic [7:0]  s_data_in;
  logic        s_data_valid;
  logic        s_clear;
  logic        s_locked;
  logic        s_err_pulse;
  logic [3:0]  s_err_count;
  logic [15:0] s_word_count;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt;

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .clear      (clear),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .word_count (word_count)
  );

  lfsr_checker #(
    .SYNC_COUNT (4),
    .LOSS_COUNT (255),
    .ERR_W      (4)
  ) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .data_in    (s_data_in),
    .data_valid (s_data_valid),
    .clear      (s_clear),
    .locked     (s_locked),
    .err_pulse  (s_err_pulse),
    .err_count  (s_err_count),
    .word_count (s_word_count)
  );

  function automatic logic [7:0] nxt(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with outputs updated.
  task automatic step(input logic v, input logic [7:0] w);
    data_valid = v;
    data_in    = w;
    @(negedge clk);
    pulse_cnt += int'(err_pulse);
  endtask

  task automatic step_clear(input logic v, input logic [7:0] w);
    clear = 1'b1;
    step(v, w);
    clear = 1'b0;
  endtask

  task automatic lock_seq(input int gap);
    logic [7:0] seq [5];
    seq = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq[i]);
      for (int g = 0; g < gap; g++) step(1'b0, 8'h00);
    end
  endtask

  task automatic s_step(input logic [7:0] w);
    s_data_valid = 1'b1;
    s_data_in    = w;
    @(negedge clk);
    s_data_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    rst = 1'b0; data_in = '0; data_valid = 1'b0; clear = 1'b0;
    s_data_in = '0; s_data_valid = 1'b0; s_clear = 1'b0;
    pulse_cnt = 0;
    #2;
    check_eq("reset_locked", 32'(locked), 32'd0);
    check_eq("reset_err_count", 32'(err_count), 32'd0);
    check_eq("reset_word_count", 32'(word_count), 32'd0);
    check_eq("reset_err_pulse", 32'(err_pulse), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Lock from seed
    step(1'b1, 8'h02); step(1'b1, 8'h04); step(1'b1, 8'h08); step(1'b1, 8'h11);
    check_eq("lock_not_early", 32'(locked), 32'd0);
    step(1'b1, 8'h23);
    check_eq("lock_locked", 32'(locked), 32'd1);
    check_eq("lock_err_count", 32'(err_count), 32'd0);
    check_eq("lock_word_count", 32'(word_count), 32'd0);

    // Clean stream: one full period starting at 0x47
    pulse_cnt = 0;
    w = 8'h47;
    for (int i = 0; i < 255; i++) begin
      step(1'b1, w);
      w = nxt(w);
    end
    check_eq("clean_word_count", 32'(word_count), 32'd255);
    check_eq("clean_err_count", 32'(err_count), 32'd0);
    check_eq("clean_pulses", 32'(pulse_cnt), 32'd0);
    check_eq("clean_locked", 32'(locked), 32'd1);
    step(1'b0, 8'h00);
    check_eq("idle_word_count", 32'(word_count), 32'd255);
    check_eq("idle_err_pulse", 32'(err_pulse), 32'd0);

    // Single corruption in place of 0x47
    step(1'b1, 8'h00);
    check_eq("corrupt_pulse", 32'(err_pulse), 32'd1);
    check_eq("corrupt_err_count", 32'(err_count), 32'd1);
    check_eq("corrupt_locked", 32'(locked), 32'd1);
    step(1'b1, 8'h8E);
    check_eq("corrupt_pulse_once", 32'(err_pulse), 32'd0);
    step(1'b1, 8'h1C);
    check_eq("corrupt_err_hold", 32'(err_count), 32'd1);
    check_eq("corrupt_word_count", 32'(word_count), 32'd258);
    check_eq("corrupt_still_locked", 32'(locked), 32'd1);

    // Loss of lock
    step_clear(1'b0, 8'h00);
    check_eq("clr_locked", 32'(locked), 32'd0);
    check_eq("clr_err_count", 32'(err_count), 32'd0);
    check_eq("clr_word_count", 32'(word_count), 32'd0);
    lock_seq(0);
    check_eq("relock_locked", 32'(locked), 32'd1);
    step(1'b1, 8'hFF); step(1'b1, 8'hFF);
    check_eq("loss_two_locked", 32'(locked), 32'd1);
    check_eq("loss_two_err", 32'(err_count), 32'd2);
    step(1'b1, 8'hFF);
    check_eq("loss_locked", 32'(locked), 32'd0);
    check_eq("loss_err_count", 32'(err_count), 32'd3);
    step(1'b1, 8'h11); step(1'b1, 8'h23); step(1'b1, 8'h47); step(1'b1, 8'h8E);
    check_eq("loss_relock_early", 32'(locked), 32'd0);
    step(1'b1, 8'h1C);
    check_eq("loss_relock", 32'(locked), 32'd1);
    check_eq("loss_err_kept", 32'(err_count), 32'd3);

    // Gapped valid, then clear with a wrong word
    step_clear(1'b0, 8'h00);
    lock_seq(2);
    check_eq("gap_locked", 32'(locked), 32'd1);
    check_eq("gap_word_count", 32'(word_count), 32'd0);
    step(1'b1, 8'h55);
    check_eq("gap_bad_err", 32'(err_count), 32'd1);
    step_clear(1'b1, 8'h13);
    check_eq("clrw_locked", 32'(locked), 32'd0);
    check_eq("clrw_err_count", 32'(err_count), 32'd0);
    check_eq("clrw_err_pulse", 32'(err_pulse), 32'd0);
    check_eq("clrw_word_count", 32'(word_count), 32'd0);

    // Async reset between clock edges
    lock_seq(0);
    step(1'b1, 8'h00);
    check_eq("pre_rst_pulse", 32'(err_pulse), 32'd1);
    data_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_eq("arst_locked", 32'(locked), 32'd0);
    check_eq("arst_err_count", 32'(err_count), 32'd0);
    check_eq("arst_word_count", 32'(word_count), 32'd0);
    check_eq("arst_err_pulse", 32'(err_pulse), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    step(1'b1, 8'h02); step(1'b1, 8'h04); step(1'b1, 8'h08); step(1'b1, 8'h11);
    check_eq("arst_relock_early", 32'(locked), 32'd0);
    step(1'b1, 8'h23);
    check_eq("arst_relock", 32'(locked), 32'd1);
    data_valid = 1'b0;

    // Saturation with ERR_W=4, LOSS_COUNT=255
    s_step(8'h02); s_step(8'h04); s_step(8'h08); s_step(8'h11); s_step(8'h23);
    check_eq("sat_locked", 32'(s_locked), 32'd1);
    for (int i = 0; i < 14; i++) s_step(8'h00);
    check_eq("sat_err_14", 32'(s_err_count), 32'd14);
    for (int i = 0; i < 6; i++) s_step(8'h00);
    check_eq("sat_err_hold", 32'(s_err_count), 32'd15);
    check_eq("sat_still_locked", 32'(s_locked), 32'd1);
    check_eq("sat_word_count", 32'(s_word_count), 32'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
